// File: rtl/dport_req_fifo_pkg.sv
// Shared types and constants for the data-port request buffer.
package dport_req_fifo_pkg;

    localparam int TAG_W_DEF = 11;

    // Request fields carried through the queue; the tag is appended separately
    // so the tag width can follow the instance parameter.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic [3:0]  wr;
        logic        cacheable;
        logic        invalidate;
        logic        writeback;
        logic        flush;
    } req_fields_t;

    // A request is present when any command bit is set.
    function automatic logic req_valid(input req_fields_t f);
        return f.rd | (|f.wr) | f.invalidate | f.writeback | f.flush;
    endfunction

endpackage

// File: rtl/dport_req_fifo_if.sv
// Data-port request/response bundle; master issues requests, slave answers.
interface dport_req_fifo_if
    import dport_req_fifo_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) ();

    logic [31:0]      addr;
    logic [31:0]      data_wr;
    logic             rd;
    logic [3:0]       wr;
    logic             cacheable;
    logic [TAG_W-1:0] req_tag;
    logic             invalidate;
    logic             writeback;
    logic             flush;
    logic             accept;
    logic             ack;
    logic             error;
    logic [31:0]      data_rd;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output addr, data_wr, rd, wr, cacheable, req_tag,
               invalidate, writeback, flush,
        input  accept, ack, error, data_rd, resp_tag
    );

    modport slave (
        input  addr, data_wr, rd, wr, cacheable, req_tag,
               invalidate, writeback, flush,
        output accept, ack, error, data_rd, resp_tag
    );

endinterface

// File: rtl/dport_req_fifo_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; no bypass path.
module dport_fifo
    import dport_req_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr_q[AW-1:0]];

    // Storage is written only on push; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/dport_req_fifo.sv
// Buffered data-port stage: queues core requests, bounds outstanding
// transactions and registers memory responses back to the core.
module dport_req_fifo
    import dport_req_fifo_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = TAG_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dport_req_fifo_if.slave   inport,
    dport_req_fifo_if.master  outport,
    output logic              unexpected_ack_o
);

    localparam int ENTRY_W = $bits(req_fields_t) + TAG_W;
    localparam int OW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

    req_fields_t        in_f;
    req_fields_t        head_f;
    logic [TAG_W-1:0]   head_tag;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept_w;
    logic               push;
    logic               pop;
    logic [OW-1:0]      outstanding_q;
    logic               ack_q;
    logic               error_q;
    logic [31:0]        data_rd_q;
    logic [TAG_W-1:0]   resp_tag_q;
    logic               unexpected_q;
    logic               dec;

    // Gather the core request fields into one entry.
    always_comb begin
        in_f            = '0;
        in_f.addr       = inport.addr;
        in_f.data       = inport.data_wr;
        in_f.rd         = inport.rd;
        in_f.wr         = inport.wr;
        in_f.cacheable  = inport.cacheable;
        in_f.invalidate = inport.invalidate;
        in_f.writeback  = inport.writeback;
        in_f.flush      = inport.flush;
    end

    assign push_data = {in_f, inport.req_tag};
    assign {head_f, head_tag} = head_data;

    // Accept depends only on registered state so the core sees no comb loop.
    assign accept_w = rst_i && !fifo_full && (outstanding_q < MAX_OUT_C);
    assign push     = req_valid(in_f) && accept_w;
    assign pop      = !fifo_empty && outport.accept;

    dport_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign inport.accept      = accept_w;
    assign outport.addr       = head_f.addr;
    assign outport.data_wr    = head_f.data;
    assign outport.cacheable  = head_f.cacheable;
    assign outport.req_tag    = head_tag;
    assign outport.rd         = head_f.rd & ~fifo_empty;
    assign outport.wr         = head_f.wr & {4{~fifo_empty}};
    assign outport.invalidate = head_f.invalidate & ~fifo_empty;
    assign outport.writeback  = head_f.writeback & ~fifo_empty;
    assign outport.flush      = head_f.flush & ~fifo_empty;

    // Response register: one-cycle ack pulse, payload captured unmodified.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q      <= 1'b0;
            error_q    <= 1'b0;
            data_rd_q  <= '0;
            resp_tag_q <= '0;
        end else begin
            ack_q <= outport.ack;
            if (outport.ack) begin
                error_q    <= outport.error;
                data_rd_q  <= outport.data_rd;
                resp_tag_q <= outport.resp_tag;
            end
        end
    end

    assign inport.ack      = ack_q;
    assign inport.error    = error_q;
    assign inport.data_rd  = data_rd_q;
    assign inport.resp_tag = resp_tag_q;

    // Decrement on delivery to the core, never below zero.
    assign dec = ack_q && (outstanding_q != '0);

    // Outstanding count: push adds one, delivered response removes one.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({push, dec})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Sticky flag for a memory ack that no request accounts for.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            unexpected_q <= 1'b0;
        end else if (outport.ack && (outstanding_q == '0) && !ack_q) begin
            unexpected_q <= 1'b1;
        end
    end

    assign unexpected_ack_o = unexpected_q;

endmodule

// File: tb/tb_dport_req_fifo.sv
// Directed bench for dport_req_fifo with hand-computed expectations.
module tb_dport_req_fifo;
    import dport_req_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic unexpected;
    int   vectors = 0;
    int   miscompares = 0;

    dport_req_fifo_if #(.TAG_W(11)) inp ();
    dport_req_fifo_if #(.TAG_W(11)) outp ();

    dport_req_fifo #(
        .DEPTH           (2),
        .MAX_OUTSTANDING (4),
        .TAG_W           (11)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .inport           (inp),
        .outport          (outp),
        .unexpected_ack_o (unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic core_idle();
        inp.rd = 1'b0;
        inp.wr = 4'h0;
        inp.invalidate = 1'b0;
        inp.writeback = 1'b0;
        inp.flush = 1'b0;
    endtask

    task automatic resp(input logic [10:0] tag, input logic [31:0] data, input logic err);
        outp.ack = 1'b1;
        outp.resp_tag = tag;
        outp.data_rd = data;
        outp.error = err;
        tick();
        outp.ack = 1'b0;
        outp.error = 1'b0;
        #1;
        chk("resp_ack", inp.ack, 1);
        chk("resp_tag", inp.resp_tag, tag);
        chk("resp_data", inp.data_rd, data);
        chk("resp_err", inp.error, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        inp.addr = '0;
        inp.data_wr = '0;
        inp.cacheable = 1'b0;
        inp.req_tag = '0;
        core_idle();
        outp.accept = 1'b0;
        outp.ack = 1'b0;
        outp.error = 1'b0;
        outp.data_rd = '0;
        outp.resp_tag = '0;

        // Reset
        @(negedge clk);
        tick();
        tick();
        #1;
        chk("rst_accept", inp.accept, 0);
        chk("rst_out_rd", outp.rd, 0);
        chk("rst_ack", inp.ack, 0);
        chk("rst_tag", inp.resp_tag, 0);
        chk("rst_data", inp.data_rd, 0);
        chk("rst_unexp", unexpected, 0);
        rst_n = 1'b1;
        tick();

        // Single read
        inp.rd = 1'b1;
        inp.addr = 32'h8000_0010;
        inp.req_tag = 11'h005;
        inp.cacheable = 1'b1;
        outp.accept = 1'b1;
        #1;
        chk("t1_accept", inp.accept, 1);
        chk("t1_nobypass", outp.rd, 0);
        tick();
        core_idle();
        #1;
        chk("t1_out_rd", outp.rd, 1);
        chk("t1_out_addr", outp.addr, 32'h8000_0010);
        chk("t1_out_tag", outp.req_tag, 11'h005);
        chk("t1_out_cache", outp.cacheable, 1);
        tick();
        #1;
        chk("t1_popped", outp.rd, 0);
        resp(11'h005, 32'hDEAD_BEEF, 1'b0);
        tick();
        #1;
        chk("t1_ack_pulse", inp.ack, 0);
        chk("t1_outst", dut.outstanding_q, 0);

        // Writes against a stalled memory
        outp.accept = 1'b0;
        inp.cacheable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            inp.wr = 4'hF;
            inp.req_tag = 11'(i);
            inp.addr = 32'h100 + 32'(i * 4);
            inp.data_wr = 32'h1000_0000 + 32'(i);
            #1;
            chk("t2_accept", inp.accept, (i <= 2) ? 1 : 0);
            if (i > 1) begin
                chk("t2_head_tag", outp.req_tag, 1);
                chk("t2_head_data", outp.data_wr, 32'h1000_0001);
            end
            tick();
        end
        #1;
        chk("t2_full_hold", inp.accept, 0);
        chk("t2_stable_tag", outp.req_tag, 1);
        chk("t2_stable_wr", outp.wr, 4'hF);
        outp.accept = 1'b1;
        tick();
        #1;
        chk("t2_order2", outp.req_tag, 2);
        chk("t2_acc3", inp.accept, 1);
        tick();
        core_idle();
        #1;
        chk("t2_order3", outp.req_tag, 3);
        chk("t2_data3", outp.data_wr, 32'h1000_0003);
        tick();
        #1;
        chk("t2_drained", outp.wr, 0);
        chk("t2_outst", dut.outstanding_q, 3);
        resp(11'd1, 32'h0, 1'b0);
        resp(11'd2, 32'h0, 1'b1);
        resp(11'd3, 32'h0, 1'b0);
        tick();
        #1;
        chk("t2_outst0", dut.outstanding_q, 0);

        // Outstanding limit
        for (int i = 1; i <= 5; i++) begin
            inp.rd = 1'b1;
            inp.req_tag = 11'(i);
            #1;
            chk("t3_accept", inp.accept, (i <= 4) ? 1 : 0);
            tick();
        end
        outp.ack = 1'b1;
        outp.resp_tag = 11'd1;
        outp.data_rd = 32'h0000_00A1;
        #1;
        chk("t3_blocked", inp.accept, 0);
        tick();
        outp.ack = 1'b0;
        #1;
        chk("t3_ack", inp.ack, 1);
        chk("t3_still_blk", inp.accept, 0);
        tick();
        #1;
        chk("t3_reenabled", inp.accept, 1);
        inp.rd = 1'b0;

        // Push and delivery in the same cycle at outstanding 3
        outp.ack = 1'b1;
        outp.resp_tag = 11'd2;
        tick();
        outp.ack = 1'b0;
        inp.rd = 1'b1;
        inp.req_tag = 11'd6;
        #1;
        chk("t4_ack", inp.ack, 1);
        chk("t4_outst_pre", dut.outstanding_q, 3);
        chk("t4_accept", inp.accept, 1);
        tick();
        core_idle();
        #1;
        chk("t4_outst_post", dut.outstanding_q, 3);
        chk("t4_accept_post", inp.accept, 1);
        chk("t4_out_tag", outp.req_tag, 6);
        resp(11'd3, 32'h3, 1'b0);
        resp(11'd4, 32'h4, 1'b0);
        resp(11'd6, 32'h6, 1'b0);
        tick();
        #1;
        chk("t4_outst0", dut.outstanding_q, 0);

        // Unexpected ack
        chk("t5_unexp_pre", unexpected, 0);
        resp(11'h7FF, 32'h1234_5678, 1'b0);
        chk("t5_unexp", unexpected, 1);
        tick();
        tick();
        #1;
        chk("t5_sticky", unexpected, 1);
        chk("t5_sat0", dut.outstanding_q, 0);

        // Reset mid-operation
        outp.accept = 1'b0;
        inp.rd = 1'b1;
        inp.req_tag = 11'd8;
        tick();
        inp.req_tag = 11'd9;
        tick();
        core_idle();
        #1;
        chk("t6_full", inp.accept, 0);
        outp.ack = 1'b1;
        outp.resp_tag = 11'd8;
        tick();
        outp.ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_ack_pend", inp.ack, 1);
        chk("t6_rst_acc", inp.accept, 0);
        tick();
        #1;
        chk("t6_out_rd", outp.rd, 0);
        chk("t6_ack", inp.ack, 0);
        chk("t6_outst", dut.outstanding_q, 0);
        chk("t6_empty", dut.fifo_empty, 1);
        chk("t6_unexp", unexpected, 0);
        chk("t6_tag", inp.resp_tag, 0);
        rst_n = 1'b1;
        tick();
        #1;
        chk("t6_accept", inp.accept, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dport_req_fifo.md
Name: dport_req_fifo

Overview:
Buffered request/response stage between the CPU data port (riscv_core mem_d_* outputs) and the data-side memory (tcm_mem mem_d_* inputs). Queues core data requests in a small FIFO and limits outstanding transactions. Registers responses back to the core with their tags intact. Decouples core accept timing from memory accept timing.

Parameters:
DEPTH, 2, request FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max accepted-but-not-responded requests (>=DEPTH)
TAG_W, 11, request/response tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-low
inport_addr_i  in  32  core request address
inport_data_wr_i  in  32  core write data
inport_rd_i  in  1  read request
inport_wr_i  in  4  byte write strobes
inport_cacheable_i  in  1  cacheable attribute
inport_req_tag_i  in  TAG_W  request tag
inport_invalidate_i / inport_writeback_i / inport_flush_i  in  1 each  cache maintenance requests
inport_accept_o  out  1  request taken this cycle
inport_ack_o  out  1  response valid
inport_error_o  out  1  response error
inport_data_rd_o  out  32  read data
inport_resp_tag_o  out  TAG_W  response tag
outport_* (addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush)  out  same widths  request to memory
outport_accept_i / outport_ack_i / outport_error_i  in  1 each  memory handshake and response
outport_data_rd_i  in  32  memory read data
outport_resp_tag_i  in  TAG_W  memory response tag
unexpected_ack_o  out  1  sticky: ack arrived with zero outstanding

Behaviour:
- Request valid (req_v) = rd | (|wr) | invalidate | writeback | flush.
- inport_accept_o = !fifo_full && (outstanding < MAX_OUTSTANDING); combinational from registered state only, never from inport inputs.
- Push when req_v && inport_accept_o; entry stores all nine request fields.
- Outport fields driven from the FIFO head. Command bits are qualified by !fifo_empty: rd/wr/invalidate/writeback/flush = 0 when empty. addr/data don't-care when empty.
- Pop when head valid && outport_accept_i. A non-accepted head holds every outport field stable.
- No bypass: a push into an empty FIFO at cycle N presents on outport at cycle N+1, earliest.
- Simultaneous push and pop when full: push is blocked because accept is deasserted. Pop frees space the next cycle.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and lower bits equal; empty = pointers equal.
- Response path is registered. outport_ack_i at cycle N produces inport_ack_o, error, data_rd and resp_tag at N+1, with all values unmodified. inport_ack_o is a one-cycle pulse per memory ack.
- outstanding counter, width log2(MAX_OUTSTANDING)+1: +1 on push, -1 on registered response delivery, unchanged when both occur in the same cycle.
- outport_ack_i with outstanding==0 and no delivery pending: unexpected_ack_o set, response still forwarded, counter saturates at 0.
- Reset values (rst_i low at a clock edge): FIFO empty, pointers 0, outstanding 0, inport_ack_o/error 0, data_rd 0, resp_tag 0, unexpected_ack_o 0, outport command bits 0.
- Reset mid-operation drops queued requests and in-flight responses. inport_accept_o = 0 while rst_i is low.

Decomposition:
- Shared package: request-entry struct (addr, data, rd, wr, cacheable, tag, invalidate, writeback, flush) and the TAG_W default constant.
- One sub-module: dport_fifo, a generic synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty.
- The top level holds the outstanding counter, accept logic and response register.

Test Plan:
- Single read, addr 0x80000010, tag 0x005, memory accepts immediately, ack one cycle later with data 0xDEADBEEF -> outport_rd at N+1; inport_ack with data 0xDEADBEEF, tag 0x005 one cycle after memory ack; outstanding returns to 0.
- outport_accept_i held 0, core issues writes wr=4'hF, tags 1,2,3 -> first two accepted; inport_accept_o drops when full (DEPTH=2); outport fields stable; releasing accept drains in order 1,2, then tag 3 is accepted.
- Memory accepts but withholds ack, core issues 5 reads -> exactly 4 accepted (MAX_OUTSTANDING); first ack re-enables accept the cycle after inport_ack_o.
- Same-cycle push and response delivery at outstanding=3 -> counter stays 3; accept stays high.
- outport_ack_i pulsed with nothing outstanding -> unexpected_ack_o = 1 and stays 1 until reset.
- Reset asserted with 2 queued requests and 1 pending ack -> next cycle outport command bits 0, inport_ack_o 0, outstanding 0, FIFO empty.
